// File: rtl/storage_to_draw_conversion.sv
// Converts a stored-object record into four screen-space points for the draw stage.
// Optional build macro S2D_CLAMP_EN saturates coordinates instead of wrapping them.
module storage_to_draw_conversion (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  input  logic        is_static,
  input  logic [1:0]  id_bits,
  input  logic [35:0] params,
  input  logic [10:0] pos_x,
  input  logic [9:0]  pos_y,
  input  logic [15:0] vel_x,
  input  logic [15:0] vel_y,
  input  logic        ready_in,
  output logic [86:0] draw_props,
  output logic        valid_out,
  output logic        busy_out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [1:0] ID_NONE   = 2'b00;
  localparam logic [1:0] ID_CIRCLE = 2'b01;
  localparam logic [1:0] ID_LINE   = 2'b10;
  localparam logic [1:0] ID_RECT   = 2'b11;

  state_t      state;
  logic [1:0]  step;
  logic        cap_static;
  logic [1:0]  cap_id;
  logic [35:0] cap_params;
  logic [10:0] cap_pos_x;
  logic [9:0]  cap_pos_y;

  // Unreduced rectangle running sum so p3 is pos+a+b even when p2 was clamped.
  logic signed [12:0] acc_x, acc_y;
  logic [10:0] p2x, p3x, p4x;
  logic [9:0]  p2y, p3y, p4y;

  logic signed [12:0] op_ax, op_ay, op_bx, op_by;
  logic signed [12:0] sum_x, sum_y;
  logic signed [12:0] radius_op;
  logic [10:0] red_x;
  logic [9:0]  red_y;
  logic        last_step;

  logic unused_vel;
  assign unused_vel = ^{vel_x, vel_y};

  always_comb begin
`ifdef S2D_CLAMP_EN
    // Any radius at or beyond 2048 saturates the same way, so cap it to keep the sum in range.
    if (|cap_params[20:11]) radius_op = 13'sd2048;
    else                    radius_op = {2'b00, cap_params[10:0]};
`else
    radius_op = {2'b00, cap_params[10:0]};
`endif
  end

  always_comb begin
    op_ax = '0;
    op_ay = '0;
    op_bx = '0;
    op_by = '0;
    case (cap_id)
      ID_CIRCLE: begin
        op_ax = {2'b00, cap_pos_x};
        op_ay = {3'b000, cap_pos_y};
        op_bx = radius_op;
      end
      ID_LINE: begin
        op_bx = {2'b00, cap_params[20:10]};
        op_by = {3'b000, cap_params[9:0]};
      end
      ID_RECT: begin
        case (step)
          2'd0: begin
            op_ax = {2'b00, cap_pos_x};
            op_ay = {3'b000, cap_pos_y};
            op_bx = {{4{cap_params[35]}}, cap_params[35:27]};
            op_by = {{4{cap_params[26]}}, cap_params[26:18]};
          end
          2'd1: begin
            op_ax = acc_x;
            op_ay = acc_y;
            op_bx = {{4{cap_params[17]}}, cap_params[17:9]};
            op_by = {{4{cap_params[8]}}, cap_params[8:0]};
          end
          default: begin
            op_ax = {2'b00, cap_pos_x};
            op_ay = {3'b000, cap_pos_y};
            op_bx = {{4{cap_params[17]}}, cap_params[17:9]};
            op_by = {{4{cap_params[8]}}, cap_params[8:0]};
          end
        endcase
      end
      default: ;
    endcase
    sum_x = op_ax + op_bx;
    sum_y = op_ay + op_by;
  end

  always_comb begin
`ifdef S2D_CLAMP_EN
    if (sum_x < 13'sd0)         red_x = '0;
    else if (sum_x > 13'sd2047) red_x = '1;
    else                        red_x = sum_x[10:0];
    if (sum_y < 13'sd0)         red_y = '0;
    else if (sum_y > 13'sd1023) red_y = '1;
    else                        red_y = sum_y[9:0];
`else
    red_x = sum_x[10:0];
    red_y = sum_y[9:0];
`endif
  end

  assign last_step = (cap_id == ID_RECT) ? (step == 2'd2) : (step == 2'd0);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= IDLE;
      step       <= '0;
      cap_static <= 1'b0;
      cap_id     <= '0;
      cap_params <= '0;
      cap_pos_x  <= '0;
      cap_pos_y  <= '0;
      acc_x      <= '0;
      acc_y      <= '0;
      p2x        <= '0;
      p2y        <= '0;
      p3x        <= '0;
      p3y        <= '0;
      p4x        <= '0;
      p4y        <= '0;
      draw_props <= '0;
      valid_out  <= 1'b0;
      busy_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            cap_static <= is_static;
            cap_id     <= id_bits;
            cap_params <= params;
            cap_pos_x  <= pos_x;
            cap_pos_y  <= pos_y;
            step       <= '0;
            acc_x      <= '0;
            acc_y      <= '0;
            p2x        <= '0;
            p2y        <= '0;
            p3x        <= '0;
            p3y        <= '0;
            p4x        <= '0;
            p4y        <= '0;
            busy_out   <= 1'b1;
            state      <= CALC;
          end
        end
        CALC: begin
          acc_x <= sum_x;
          acc_y <= sum_y;
          case (step)
            2'd0: begin
              p2x <= red_x;
              p2y <= red_y;
            end
            2'd1: begin
              p3x <= red_x;
              p3y <= red_y;
            end
            default: begin
              p4x <= red_x;
              p4y <= red_y;
            end
          endcase
          if (last_step) state <= DONE;
          else           step  <= step + 2'd1;
        end
        DONE: begin
          // First DONE cycle publishes the result; the handshake only completes once it is visible.
          if (!valid_out) begin
            draw_props <= {cap_static, cap_id,
                           (cap_id == ID_NONE) ? 11'd0 : cap_pos_x,
                           (cap_id == ID_NONE) ? 10'd0 : cap_pos_y,
                           p2x, p2y, p3x, p3y, p4x, p4y};
            valid_out  <= 1'b1;
          end else if (ready_in) begin
            valid_out <= 1'b0;
            busy_out  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_storage_to_draw_conversion.sv
// Directed-vector bench for storage_to_draw_conversion; expected values are hand-computed.
module tb_storage_to_draw_conversion;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic        is_static;
  logic [1:0]  id_bits;
  logic [35:0] params;
  logic [10:0] pos_x;
  logic [9:0]  pos_y;
  logic [15:0] vel_x;
  logic [15:0] vel_y;
  logic        ready_in;
  logic [86:0] draw_props;
  logic        valid_out;
  logic        busy_out;

  int vectors = 0;
  int miscompares = 0;
  int lat;
  logic seen;
  logic [86:0] exp_line;

  storage_to_draw_conversion dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .is_static(is_static),
    .id_bits(id_bits), .params(params), .pos_x(pos_x), .pos_y(pos_y),
    .vel_x(vel_x), .vel_y(vel_y), .ready_in(ready_in),
    .draw_props(draw_props), .valid_out(valid_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [86:0] got, input logic [86:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [86:0] props(input logic st, input logic [1:0] id,
      input logic [10:0] ax, input logic [9:0] ay, input logic [10:0] bx, input logic [9:0] by,
      input logic [10:0] cx, input logic [9:0] cy, input logic [10:0] dx, input logic [9:0] dy);
    return {st, id, ax, ay, bx, by, cx, cy, dx, dy};
  endfunction

  task automatic xfer(input logic st, input logic [1:0] id, input logic [35:0] prm,
                      input logic [10:0] px, input logic [9:0] py);
    @(negedge clk_in);
    is_static = st;
    id_bits   = id;
    params    = prm;
    pos_x     = px;
    pos_y     = py;
    vel_x     = 16'hBEEF;
    vel_y     = 16'h1234;
    valid_in  = 1'b1;
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    logic found;
    found  = 1'b0;
    cycles = -1;
    for (int k = 1; k <= 20 && !found; k++) begin
      @(posedge clk_in);
      #1;
      if (valid_out) begin
        found  = 1'b1;
        cycles = k;
      end
    end
  endtask

  task automatic run(input string tag, input logic st, input logic [1:0] id, input logic [35:0] prm,
                     input logic [10:0] px, input logic [9:0] py, input logic [86:0] exp, input int exp_lat);
    int l;
    ready_in = 1'b1;
    xfer(st, id, prm, px, py);
    check({tag, "_busy"}, busy_out, 1'b1);
    wait_valid(l);
    check({tag, "_lat"}, l, exp_lat);
    check({tag, "_props"}, draw_props, exp);
    @(posedge clk_in);
    #1;
    check({tag, "_valid_drop"}, valid_out, 1'b0);
    check({tag, "_idle"}, busy_out, 1'b0);
  endtask

  initial begin
    rst_in = 1'b1; valid_in = 1'b0; ready_in = 1'b0; is_static = 1'b0; id_bits = '0;
    params = '0; pos_x = '0; pos_y = '0; vel_x = '0; vel_y = '0;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_props", draw_props, '0);
    check("rst_valid", valid_out, 1'b0);
    check("rst_busy", busy_out, 1'b0);
    @(negedge clk_in);
    rst_in = 1'b0;

    exp_line = props(1'b0, 2'b10, 11'd100, 10'd50, 11'd300, 10'd200, 11'd0, 10'd0, 11'd0, 10'd0);
    run("line", 1'b0, 2'b10, {15'd0, 11'd300, 10'd200}, 11'd100, 10'd50, exp_line, 2);

    run("circle", 1'b1, 2'b01, {15'd0, 21'd25}, 11'd400, 10'd300,
        props(1'b1, 2'b01, 11'd400, 10'd300, 11'd425, 10'd300, 11'd0, 10'd0, 11'd0, 10'd0), 2);

    run("rect", 1'b0, 2'b11, {9'd30, 9'd5, 9'h1FB, 9'd40}, 11'd10, 10'd20,
        props(1'b0, 2'b11, 11'd10, 10'd20, 11'd40, 10'd25, 11'd35, 10'd65, 11'd5, 10'd60), 4);

`ifdef S2D_CLAMP_EN
    run("clamp", 1'b0, 2'b11, {9'h1F6, 9'h1F6, 18'd0}, 11'd2, 10'd3,
        props(1'b0, 2'b11, 11'd2, 10'd3, 11'd0, 10'd0, 11'd0, 10'd0, 11'd2, 10'd3), 4);
    run("circle_sat", 1'b0, 2'b01, {15'd0, 21'd100000}, 11'd10, 10'd7,
        props(1'b0, 2'b01, 11'd10, 10'd7, 11'd2047, 10'd7, 11'd0, 10'd0, 11'd0, 10'd0), 2);
`else
    run("wrap", 1'b0, 2'b11, {9'h1F6, 9'h1F6, 18'd0}, 11'd2, 10'd3,
        props(1'b0, 2'b11, 11'd2, 10'd3, 11'd2040, 10'd1017, 11'd2040, 10'd1017, 11'd2, 10'd3), 4);
    run("circle_wrap", 1'b0, 2'b01, {15'd0, 21'd2100}, 11'd10, 10'd7,
        props(1'b0, 2'b01, 11'd10, 10'd7, 11'd62, 10'd7, 11'd0, 10'd0, 11'd0, 10'd0), 2);
`endif

    run("undef", 1'b1, 2'b00, 36'hFEDCBA987, 11'd5, 10'd6,
        props(1'b1, 2'b00, 11'd0, 10'd0, 11'd0, 10'd0, 11'd0, 10'd0, 11'd0, 10'd0), 2);

    // Backpressure: result must hold while ready_in is low, and a valid_in pulse is dropped.
    ready_in = 1'b0;
    xfer(1'b0, 2'b10, {15'd0, 11'd300, 10'd200}, 11'd100, 10'd50);
    wait_valid(lat);
    check("bp_lat", lat, 2);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", valid_out, 1'b1);
      check("bp_props", draw_props, exp_line);
      @(negedge clk_in);
      valid_in = (i == 2);
      id_bits  = 2'b01;
      pos_x    = 11'd7;
      @(posedge clk_in);
      #1;
      valid_in = 1'b0;
    end
    @(negedge clk_in);
    ready_in = 1'b1;
    @(posedge clk_in);
    #1;
    check("bp_release_valid", valid_out, 1'b0);
    check("bp_release_idle", busy_out, 1'b0);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk_in);
      #1;
      if (valid_out || busy_out) seen = 1'b1;
    end
    check("bp_no_queue", seen, 1'b0);

    // Reset during rectangle step 1 discards the conversion.
    xfer(1'b1, 2'b11, {9'd30, 9'd5, 9'h1FB, 9'd40}, 11'd10, 10'd20);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    #1;
    check("midrst_props", draw_props, '0);
    check("midrst_valid", valid_out, 1'b0);
    check("midrst_busy", busy_out, 1'b0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk_in);
      #1;
      if (valid_out) seen = 1'b1;
    end
    check("midrst_no_valid", seen, 1'b0);

    // A transfer presented as reset releases is taken on the very next edge.
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in    = 1'b0;
    is_static = 1'b0;
    id_bits   = 2'b01;
    params    = {15'd0, 21'd25};
    pos_x     = 11'd400;
    pos_y     = 10'd300;
    valid_in  = 1'b1;
    ready_in  = 1'b1;
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
    check("postrst_accept", busy_out, 1'b1);
    wait_valid(lat);
    check("postrst_lat", lat, 2);
    check("postrst_props", draw_props,
          props(1'b0, 2'b01, 11'd400, 10'd300, 11'd425, 10'd300, 11'd0, 10'd0, 11'd0, 10'd0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/storage_to_draw_conversion.md
STORAGE_TO_DRAW_CONVERSION -- requirements
Module: storage_to_draw_conversion

Interface
REQ-001 SHALL have port clk_in, input, 1 bit; the single clock, with all state updated on its rising edge.
REQ-002 SHALL have port rst_in, input, 1 bit; reset is asynchronous and active-high.
REQ-003 SHALL have port valid_in, input, 1 bit; the stored-object fields are valid this cycle.
REQ-004 SHALL have ports is_static (1), id_bits (2), params (36), pos_x (11), pos_y (10), vel_x (16) and vel_y (16), all inputs, carrying the stored-object fields.
REQ-005 SHALL have port ready_in, input, 1 bit; the downstream consumer accepts draw_props this cycle.
REQ-006 SHALL have port draw_props, output, 87 bits, laid out as follows:
- [86] is_static
- [85:84] id_bits
- [83:73] p1x, [72:63] p1y
- [62:52] p2x, [51:42] p2y
- [41:31] p3x, [30:21] p3y
- [20:10] p4x, [9:0] p4y
REQ-007 SHALL have port valid_out, output, 1 bit; draw_props holds a finished conversion.
REQ-008 SHALL have port busy_out, output, 1 bit; high whenever the state is not IDLE.

Function
REQ-009 SHALL use FSM states IDLE, CALC and DONE.
REQ-010 SHALL accept a transfer only when valid_in=1 and state=IDLE. On that edge it registers all inputs, clears the step counter, and moves to CALC.
REQ-011 SHALL ignore valid_in while busy_out=1, with no queuing and no state change.
REQ-012 SHALL compute one point per CALC edge with a single shared adder, and SHALL move to DONE on the last step.
REQ-013 SHALL use this CALC step count per id_bits: 00 → 1, 01 → 1, 10 → 1, 11 → 3.
REQ-014 SHALL raise valid_out 2 cycles after the accept edge for id 00/01/10, and 4 cycles after it for id 11.
REQ-015 SHALL hold valid_out and draw_props stable in DONE until ready_in=1. The edge with ready_in=1 moves the state to IDLE, and valid_out is low on the following cycle.
REQ-016 SHALL, for id 00 (undefined), output p1 through p4 all zero and still complete the handshake.
REQ-017 SHALL, for id 01 (circle), output p1=(pos_x,pos_y) and p2=(pos_x+r, pos_y), where r=params[20:0] unsigned; p3 and p4 are zero.
REQ-018 SHALL, for id 10 (line), output p1=(pos_x,pos_y) and p2=(params[20:10], params[9:0]); p3 and p4 are zero.
REQ-019 SHALL, for id 11 (rectangle), decode these 9-bit two's-complement edge vectors:
- a=(params[35:27], params[26:18])
- b=(params[17:9], params[8:0])
REQ-020 SHALL output rectangle corners p1=pos, p2=pos+a, p3=pos+a+b and p4=pos+b, computing p2, p3 and p4 in CALC steps 0, 1 and 2 respectively.
REQ-021 SHALL perform all point arithmetic sign-extended to 13 bits before the final width reduction.
REQ-022 SHALL pass is_static and id_bits through unchanged, and SHALL ignore vel_x and vel_y.
REQ-023 SHALL give a reset asserted in any state priority over any simultaneous valid_in or ready_in.

Reset
REQ-024 SHALL, while rst_in=1, force state=IDLE, draw_props=0, valid_out=0, busy_out=0, step counter=0, and all captured registers to 0.
REQ-025 SHALL discard an in-flight conversion when reset is asserted mid-operation, and SHALL produce no valid_out for it after release.
REQ-026 SHALL accept a new transfer on the first rising edge after rst_in deasserts.

Configuration
REQ-027 SHALL, with macro S2D_CLAMP_EN defined, saturate each computed coordinate to x∈[0,2047] and y∈[0,1023]. Negative results become 0; overflow becomes the maximum.
REQ-028 SHALL, with S2D_CLAMP_EN undefined, truncate each computed coordinate modulo 2^11 for x and 2^10 for y.

Verification
REQ-029 SHALL cover a line: id=10, pos=(100,50), params[20:0]={11'd300,10'd200}, ready_in=1. Required: valid_out 2 cycles after accept, p1=(100,50), p2=(300,200), p3=p4=0.
REQ-030 SHALL cover a circle: id=01, pos=(400,300), r=25. Required: p1=(400,300), p2=(425,300), valid_out at +2 cycles.
REQ-031 SHALL cover a rectangle: id=11, pos=(10,20), a=(+30,+5), b=(-5,+40). Required: p2=(40,25), p3=(35,65), p4=(5,60), valid_out at +4 cycles.
REQ-032 SHALL cover clamp behaviour: id=11, pos=(2,3), a=(-10,-10), b=0.
- With S2D_CLAMP_EN defined: p2=(0,0).
- Without it: p2=(2040,1017).
REQ-033 SHALL cover backpressure: hold ready_in=0 for 5 cycles after valid_out rises. Required: draw_props and valid_out stay stable; a valid_in pulse during this window is ignored; after ready_in=1, IDLE is reached 1 cycle later.
REQ-034 SHALL cover reset mid-operation: assert rst_in during rectangle CALC step 1. Required: all outputs become 0 immediately, and no valid_out follows the release.
